// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// hazard priority levels and the decode from hazard level to stage controls.
package hazard_ctrl_pkg;

    localparam int RD_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    // Larger value means higher priority.
    typedef enum logic [2:0] {
        PRIO_NONE      = 3'd0,
        PRIO_LOAD_USE  = 3'd1,
        PRIO_JUMP      = 3'd2,
        PRIO_MEM_STALL = 3'd3,
        PRIO_ERR       = 3'd4
    } hazard_e;

    typedef struct packed {
        logic hold_pc;
        logic hold_if_id;
        logic hold_id_ex;
        logic hold_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
    } ctrl_t;

    function automatic ctrl_t decode_hazard(input hazard_e hazard);
        ctrl_t ctrl;
        ctrl = '0;
        case (hazard)
            PRIO_ERR, PRIO_MEM_STALL: begin
                ctrl.hold_pc     = 1'b1;
                ctrl.hold_if_id  = 1'b1;
                ctrl.hold_id_ex  = 1'b1;
                ctrl.hold_ex_mem = 1'b1;
            end
            PRIO_JUMP: begin
                ctrl.flush_if_id = 1'b1;
                ctrl.flush_id_ex = 1'b1;
            end
            PRIO_LOAD_USE: begin
                ctrl.hold_pc     = 1'b1;
                ctrl.hold_if_id  = 1'b1;
                ctrl.flush_id_ex = 1'b1;
            end
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, taken-jump and data-memory wait
// hazards mapped onto stage hold/flush controls, with watchdog and counters.
module hazard_ctrl #(
    parameter int RD_WIDTH    = hazard_ctrl_pkg::RD_WIDTH,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RD_WIDTH-1:0]  rs1_id,
    input  logic [RD_WIDTH-1:0]  rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic [RD_WIDTH-1:0]  rd_ex,
    input  logic                 mem_read_ex,
    input  logic                 jump_ex,
    input  logic                 dmem_req_mem,
    input  logic                 dmem_ready,
    output logic                 hold_pc,
    output logic                 hold_if_id,
    output logic                 hold_id_ex,
    output logic                 hold_ex_mem,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    import hazard_ctrl_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic    mem_stall;
    logic    load_use;
    hazard_e hazard;
    ctrl_t   ctrl;

    assign mem_stall = dmem_req_mem & ~dmem_ready;
    assign load_use  = mem_read_ex & (rd_ex != '0) &
                       ((rs1_used_id & (rs1_id == rd_ex)) |
                        (rs2_used_id & (rs2_id == rd_ex)));

    always_comb begin
        hazard = PRIO_NONE;
        if (state_q == ERR) begin
            hazard = PRIO_ERR;
        end else if (mem_stall) begin
            hazard = PRIO_MEM_STALL;
        end else if (jump_ex) begin
            hazard = PRIO_JUMP;
        end else if (load_use) begin
            hazard = PRIO_LOAD_USE;
        end
    end

    // Controls are forced quiet while reset is held so no stage sees a stray hold.
    assign ctrl = rst_n ? decode_hazard(hazard) : '0;

    assign hold_pc     = ctrl.hold_pc;
    assign hold_if_id  = ctrl.hold_if_id;
    assign hold_id_ex  = ctrl.hold_id_ex;
    assign hold_ex_mem = ctrl.hold_ex_mem;
    assign flush_if_id = ctrl.flush_if_id;
    assign flush_id_ex = ctrl.flush_id_ex;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                // A dropped request without ready is treated like completion.
                if (dmem_ready || !dmem_req_mem) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.hold_pc),
        .count (stall_cnt)
    );

    // Only the jump hazard raises flush_if_id, so it marks an applied jump.
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl.flush_if_id),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int RDW     = 5;
    localparam int TIMEOUT = 4;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_HOLDS = 6'b111100;
    localparam logic [5:0] O_JUMP  = 6'b000011;
    localparam logic [5:0] O_LOAD  = 6'b110001;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [RDW-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic           rs1_used_id = 1'b0, rs2_used_id = 1'b0;
    logic           mem_read_ex = 1'b0, jump_ex = 1'b0;
    logic           dmem_req_mem = 1'b0, dmem_ready = 1'b0;
    logic           hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
    logic           flush_if_id, flush_id_ex, mem_timeout;
    logic [CW-1:0]  stall_cnt, flush_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .RD_WIDTH    (RDW),
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rs1_used_id  (rs1_used_id),
        .rs2_used_id  (rs2_used_id),
        .rd_ex        (rd_ex),
        .mem_read_ex  (mem_read_ex),
        .jump_ex      (jump_ex),
        .dmem_req_mem (dmem_req_mem),
        .dmem_ready   (dmem_ready),
        .hold_pc      (hold_pc),
        .hold_if_id   (hold_if_id),
        .hold_id_ex   (hold_id_ex),
        .hold_ex_mem  (hold_ex_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    function automatic logic [5:0] outs();
        return {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex};
    endfunction

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        mem_read_ex = 1'b0; jump_ex = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dmem_req_mem = 1'b1; jump_ex = 1'b1; mem_read_ex = 1'b1;
        rd_ex = 5'd3; rs1_id = 5'd3; rs1_used_id = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ctrl got=%b want=%b", outs(), O_NONE);
        end
        n_compared++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        n_compared++;
        if (mem_timeout !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_timeout got=%b want=0", mem_timeout);
        end
        n_compared++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        apply_reset();
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        #1;
        if (outs() !== O_LOAD) begin
            n_mismatched++;
            $display("[TB] FAIL load_use_ctrl got=%b want=%b", outs(), O_LOAD);
        end
        n_compared++;
        @(negedge clk);
        clear_inputs();
        #1;
        if (outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL load_use_single got=%b want=%b", outs(), O_NONE);
        end
        n_compared++;
        if (stall_cnt !== CW'(1)) begin
            n_mismatched++;
            $display("[TB] FAIL load_use_stall_cnt got=%0d want=1", stall_cnt);
        end
        n_compared++;
        mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used_id = 1'b1; rs1_id = 5'd9;
        #1;
        if (outs() !== O_LOAD) begin
            n_mismatched++;
            $display("[TB] FAIL load_use_rs2 got=%b want=%b", outs(), O_LOAD);
        end
        n_compared++;
        clear_inputs();
    endtask

    task automatic test_rd_zero();
        apply_reset();
        mem_read_ex = 1'b1; rd_ex = '0; rs1_id = '0; rs1_used_id = 1'b1;
        #1;
        if (outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL rd_zero_ctrl got=%b want=%b", outs(), O_NONE);
        end
        n_compared++;
        @(negedge clk);
        clear_inputs();
        #1;
        if (stall_cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rd_zero_stall_cnt got=%0d want=0", stall_cnt);
        end
        n_compared++;
    endtask

    task automatic test_jump_over_load_use();
        apply_reset();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs1_used_id = 1'b1;
        jump_ex = 1'b1;
        #1;
        if (outs() !== O_JUMP) begin
            n_mismatched++;
            $display("[TB] FAIL jump_ctrl got=%b want=%b", outs(), O_JUMP);
        end
        n_compared++;
        @(negedge clk);
        clear_inputs();
        #1;
        if (flush_cnt !== CW'(1) || stall_cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL jump_counters got=%0d/%0d want=1/0", flush_cnt, stall_cnt);
        end
        n_compared++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            dmem_req_mem = 1'b1; dmem_ready = 1'b0;
            #1;
            if (outs() !== O_HOLDS) begin
                n_mismatched++;
                $display("[TB] FAIL mem_wait_hold[%0d] got=%b want=%b", i, outs(), O_HOLDS);
            end
            n_compared++;
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        if (outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL mem_wait_release got=%b want=%b", outs(), O_NONE);
        end
        n_compared++;
        @(negedge clk);
        clear_inputs();
        #1;
        if (stall_cnt !== CW'(3) || mem_timeout !== 1'b0 || outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL mem_wait_after got=cnt%0d/to%b/%b want=cnt3/to0/%b",
                     stall_cnt, mem_timeout, outs(), O_NONE);
        end
        n_compared++;
    endtask

    task automatic test_stall_with_jump();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            dmem_req_mem = 1'b1; dmem_ready = 1'b0; jump_ex = 1'b1;
            #1;
            if (outs() !== O_HOLDS) begin
                n_mismatched++;
                $display("[TB] FAIL stall_jump_hold[%0d] got=%b want=%b", i, outs(), O_HOLDS);
            end
            n_compared++;
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        #1;
        if (outs() !== O_JUMP) begin
            n_mismatched++;
            $display("[TB] FAIL stall_jump_release got=%b want=%b", outs(), O_JUMP);
        end
        n_compared++;
        @(negedge clk);
        clear_inputs();
        #1;
        if (flush_cnt !== CW'(1) || stall_cnt !== CW'(2)) begin
            n_mismatched++;
            $display("[TB] FAIL stall_jump_counters got=%0d/%0d want=1/2", flush_cnt, stall_cnt);
        end
        n_compared++;
    endtask

    task automatic test_illegal_drop();
        apply_reset();
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dmem_req_mem = 1'b0;
        #1;
        if (outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL drop_release got=%b want=%b", outs(), O_NONE);
        end
        n_compared++;
        // A fresh stall of TIMEOUT-1 cycles must not time out if the wait restarted.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            @(negedge clk);
            dmem_req_mem = 1'b1;
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        if (mem_timeout !== 1'b0 || outs() !== O_NONE) begin
            n_mismatched++;
            $display("[TB] FAIL drop_restart got=to%b/%b want=to0/%b", mem_timeout, outs(), O_NONE);
        end
        n_compared++;
    endtask

    task automatic test_timeout_async_reset();
        apply_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            dmem_req_mem = 1'b1; dmem_ready = 1'b0;
            #1;
            if (outs() !== O_HOLDS || mem_timeout !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL timeout_pre[%0d] got=%b/to%b want=%b/to0",
                         i, outs(), mem_timeout, O_HOLDS);
            end
            n_compared++;
            @(negedge clk);
        end
        dmem_req_mem = 1'b0;
        #1;
        if (outs() !== O_HOLDS || mem_timeout !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_err got=%b/to%b want=%b/to1", outs(), mem_timeout, O_HOLDS);
        end
        n_compared++;
        repeat (CNT_MAX + 8) @(negedge clk);
        #1;
        if (stall_cnt !== CW'(CNT_MAX)) begin
            n_mismatched++;
            $display("[TB] FAIL stall_saturate got=%0d want=%0d", stall_cnt, CNT_MAX);
        end
        n_compared++;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (outs() !== O_NONE || mem_timeout !== 1'b0 || stall_cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset got=%b/to%b/cnt%0d want=%b/to0/cnt0",
                     outs(), mem_timeout, stall_cnt, O_NONE);
        end
        n_compared++;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_req_mem = 1'b1;
        #1;
        if (outs() !== O_HOLDS) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_stall got=%b want=%b", outs(), O_HOLDS);
        end
        n_compared++;
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        if (outs() !== O_NONE || mem_timeout !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_run got=%b/to%b want=%b/to0", outs(), mem_timeout, O_NONE);
        end
        n_compared++;
        clear_inputs();
    endtask

    task automatic test_flush_saturate();
        apply_reset();
        jump_ex = 1'b1;
        repeat (CNT_MAX + 8) @(negedge clk);
        #1;
        if (flush_cnt !== CW'(CNT_MAX) || stall_cnt !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL flush_saturate got=%0d/%0d want=%0d/0", flush_cnt, stall_cnt, CNT_MAX);
        end
        n_compared++;
        clear_inputs();
    endtask

    // Model: the watchdog trips once a memory stall has lasted TIMEOUT cycles in a row.
    task automatic test_random();
        int         m_consec, m_stall, m_flush;
        bit         m_err, stall, lu;
        logic [5:0] exp;
        for (int blk = 0; blk < 6; blk++) begin
            apply_reset();
            m_consec = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (cyc != 0) @(negedge clk);
                rs1_id       = RDW'($urandom_range(0, 3));
                rs2_id       = RDW'($urandom_range(0, 3));
                rd_ex        = RDW'($urandom_range(0, 3));
                rs1_used_id  = 1'($urandom_range(0, 1));
                rs2_used_id  = 1'($urandom_range(0, 1));
                mem_read_ex  = 1'($urandom_range(0, 1));
                jump_ex      = ($urandom_range(0, 4) == 0);
                dmem_req_mem = ($urandom_range(0, 2) == 0) || (m_consec != 0 && $urandom_range(0, 3) != 0);
                dmem_ready   = ($urandom_range(0, 2) == 0);
                #1;
                stall = dmem_req_mem && !dmem_ready;
                lu = mem_read_ex && (rd_ex != 0) &&
                     ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
                if (m_err || stall) exp = O_HOLDS;
                else if (jump_ex)   exp = O_JUMP;
                else if (lu)        exp = O_LOAD;
                else                exp = O_NONE;
                if (outs() !== exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_ctrl[%0d.%0d] got=%b want=%b", blk, cyc, outs(), exp);
                end
                n_compared++;
                if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || mem_timeout !== m_err) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_state[%0d.%0d] got=%0d/%0d/to%b want=%0d/%0d/to%b",
                             blk, cyc, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_err);
                end
                n_compared++;
                if (exp[5] && m_stall < CNT_MAX) m_stall++;
                if (exp == O_JUMP && m_flush < CNT_MAX) m_flush++;
                if (!m_err) begin
                    m_consec = stall ? m_consec + 1 : 0;
                    if (m_consec == TIMEOUT) m_err = 1'b1;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_jump_over_load_use();
        test_mem_wait();
        test_stall_with_jump();
        test_illegal_drop();
        test_timeout_async_reset();
        test_flush_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the hold and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects three conditions:
  - load-use hazards between ID and EX;
  - taken control transfers resolved in EX;
  - multi-cycle data-memory accesses in MEM.
- Runs a wait FSM with a timeout watchdog, plus stall and flush performance counters.

Parameters:
- RD_WIDTH, 5, register index width (rs1/rs2/rd).
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before the error state; must be ≥2.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rs1_id  in  RD_WIDTH  rs1 index of instruction in ID
- rs2_id  in  RD_WIDTH  rs2 index of instruction in ID
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- rd_ex  in  RD_WIDTH  destination of instruction in EX
- mem_read_ex  in  1  EX instruction is a load
- jump_ex  in  1  taken branch/jal/jalr resolved in EX
- dmem_req_mem  in  1  MEM stage has an outstanding data access
- dmem_ready  in  1  data memory completes the access this cycle
- hold_pc  out  1  PC keeps its value
- hold_if_id  out  1  IF/ID keeps its contents
- hold_id_ex  out  1  ID/EX keeps its contents
- hold_ex_mem  out  1  EX/MEM keeps its contents
- flush_if_id  out  1  IF/ID loads a bubble
- flush_id_ex  out  1  ID/EX loads a bubble (drives the ID/EX flush input)
- mem_timeout  out  1  sticky watchdog error
- stall_cnt  out  CNT_WIDTH  cycles with hold_pc=1
- flush_cnt  out  CNT_WIDTH  cycles with jump flush applied

Behaviour:
- Reset is asynchronous:
  - state=RUN, wait_cnt=0;
  - stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - While rst_n=0, all hold/flush outputs are 0.
- Hold and flush outputs are combinational from state and inputs, so they are valid in the same cycle they are sampled. Counters and FSM update on posedge clk.
- mem_stall = dmem_req_mem & ~dmem_ready.
- load_use = mem_read_ex & (rd_ex≠0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- Output priority, highest first:
  1. ERR state: all four holds=1, flushes=0.
  2. mem_stall: all four holds=1, flushes=0. EX is frozen, so jump_ex stays stable and is honoured on the release cycle.
  3. jump_ex: flush_if_id=1, flush_id_ex=1, holds=0. Jump overrides load_use, because the ID instruction is wrong-path.
  4. load_use: hold_pc=1, hold_if_id=1, flush_id_ex=1; others 0. Exactly one bubble, then resolved by forwarding.
  5. Otherwise all 0.
- FSM states and transitions:
  - RUN:
    - mem_stall → MEM_WAIT, wait_cnt←1.
    - Otherwise stay.
  - MEM_WAIT:
    - dmem_ready → RUN, wait_cnt←0. Holds drop in this same cycle.
    - Else if wait_cnt==MEM_TIMEOUT-1 → ERR, mem_timeout←1.
    - Else wait_cnt+1.
  - ERR: terminal until rst_n is asserted.
- dmem_req_mem deasserting in MEM_WAIT without ready is illegal. The FSM returns to RUN and holds release.
- Counters:
  - stall_cnt increments on each cycle with hold_pc=1.
  - flush_cnt increments on each cycle where jump_ex is applied (priority 3).
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-wait: all outputs drop immediately, and the FSM is in RUN on release.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2;
  - RD_WIDTH;
  - the hazard priority constants.
- One natural sub-module: sat_counter, a parameterised saturating counter with enable, instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle → hold_pc=hold_if_id=flush_id_ex=1 for exactly 1 cycle; stall_cnt=1.
- rd_ex=0 with a matching rs1 → no hold, no flush; stall_cnt unchanged.
- Jump together with load-use: jump_ex=1 and the load_use condition true → flush_if_id=flush_id_ex=1, hold_pc=0; flush_cnt=1.
- Memory wait: dmem_req_mem=1 with dmem_ready low for 3 cycles, then high → all holds=1 for 3 cycles, 0 on the ready cycle; FSM returns to RUN; stall_cnt=3.
- Stall with jump: jump_ex=1 held during a 2-cycle mem_stall → no flush while stalled; flush asserted on the release cycle.
- Timeout then async reset: MEM_TIMEOUT=4, ready never asserted → ERR entered after 4 stall cycles; mem_timeout=1; holds stay 1 → asynchronous rst_n pulse mid-cycle clears everything immediately.
